// File: rtl/if_id_skid_stage.sv
// IF/ID stage: two-entry skid buffer between fetch and decode,
// with flush, NOP insertion and a saturating stall counter.
module if_id_skid_stage #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W = 30,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Flush,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [INSTR_W-1:0] Instr_in,
  input  logic [PC_W-1:0]    PC_in,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [INSTR_W-1:0] Instr_out,
  output logic [PC_W-1:0]    PC_out,
  output logic [CNT_W-1:0]   Stall_cnt
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  ent_t   r_main;
  ent_t   r_skid;
  ent_t   w_main_nxt;
  ent_t   w_skid_nxt;
  ent_t   w_in;
  logic   r_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_consume;
  logic   w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in.instr  = Instr_in;
  assign w_in.pc     = PC_in;
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = In_valid & r_in_ready;
  assign w_consume   = w_out_valid & Out_ready;
  assign w_stall     = w_out_valid & ~Out_ready & ~Flush;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (Flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_main_nxt  = w_in;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_consume) begin
            w_main_nxt = w_in;
          end else if (w_accept) begin
            w_skid_nxt  = w_in;
            w_state_nxt = S_FULL;
          end else if (w_consume) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_consume) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != S_FULL);
    end
  end

  // Saturates rather than wraps so long stalls stay visible.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign In_ready  = r_in_ready;
  assign Out_valid = w_out_valid;
  assign Instr_out = w_out_valid ? r_main.instr : NOP_INSTR;
  assign PC_out    = w_out_valid ? r_main.pc : '0;
  assign Stall_cnt = r_stall_cnt;

endmodule
